// File: rtl/rptr_sync_decoder_if.sv
// Bundle between the write pointer handler and the read-pointer receiver in the write domain.
// master drives the pointers and requests; slave returns synchronized pointer, level and flags.
interface rptr_sync_decoder_if #(
  parameter int PTR_WIDTH = 3
) ();
  logic [PTR_WIDTH:0] g_rptr;
  logic [PTR_WIDTH:0] b_wptr;
  logic               w_en;
  logic               full;
  logic               err_clr;
  logic [PTR_WIDTH:0] g_rptr_sync;
  logic [PTR_WIDTH:0] b_rptr_sync;
  logic [PTR_WIDTH:0] w_level;
  logic               almost_full;
  logic               overflow;
  logic               gray_err;

  modport master (
    output g_rptr, b_wptr, w_en, full, err_clr,
    input  g_rptr_sync, b_rptr_sync, w_level, almost_full, overflow, gray_err
  );

  modport slave (
    input  g_rptr, b_wptr, w_en, full, err_clr,
    output g_rptr_sync, b_rptr_sync, w_level, almost_full, overflow, gray_err
  );
endinterface

// File: rtl/rptr_sync_decoder.sv
// Write-domain receiver of the async FIFO Gray read pointer: sync chain, Gray->binary, level, flags.
// Latency SYNC_STAGES to g_rptr_sync, +1 to b_rptr_sync, +2 to w_level/almost_full; no backpressure.
module rptr_sync_decoder #(
  parameter int PTR_WIDTH   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  rptr_sync_decoder_if.slave   bus
);
  localparam int PW = PTR_WIDTH;
  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [PW:0]   DEPTH_P = {1'b1, {PW{1'b0}}};
  localparam logic [PW:0]   AF_T    = AF_THRESH[PW:0];
  localparam logic [CW-1:0] SUP_END = CW'(SYNC_STAGES);

  logic [PW:0]   r_sync [SYNC_STAGES];
  logic [PW:0]   r_b_rptr;
  logic [PW:0]   r_level;
  logic          r_af;
  logic          r_ovf;
  logic          r_gerr;
  logic [CW-1:0] r_sup_cnt;

  logic [PW:0] w_g;
  logic [PW:0] w_b_dec;
  logic [PW:0] w_level_next;
  logic [PW:0] w_diff;
  logic        w_chk_en;
  logic        w_gray_bad;
  logic        w_ovf_set;

  assign w_g = r_sync[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_b_dec = '0;
    for (int i = 0; i <= PW; i++) begin
      w_b_dec[i] = ^(w_g >> i);
    end
  end

  assign w_level_next = bus.b_wptr - r_b_rptr;
  assign w_diff       = r_sync[SYNC_STAGES-2] ^ r_sync[SYNC_STAGES-1];
  // More than one bit set <=> clearing the lowest set bit leaves something behind.
  assign w_chk_en     = (r_sup_cnt == SUP_END);
  assign w_gray_bad   = w_chk_en &&
                        (((w_diff & (w_diff - 1'b1)) != '0) || (w_level_next > DEPTH_P));
  assign w_ovf_set    = bus.w_en & bus.full;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_b_rptr  <= '0;
      r_level   <= '0;
      r_af      <= 1'b0;
      r_ovf     <= 1'b0;
      r_gerr    <= 1'b0;
      r_sup_cnt <= '0;
    end else begin
      r_sync[0] <= bus.g_rptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_b_rptr <= w_b_dec;
      r_level  <= w_level_next;
      r_af     <= (w_level_next >= AF_T);
      // Integrity check stays off until the chain has refilled after reset.
      if (r_sup_cnt != SUP_END) begin
        r_sup_cnt <= r_sup_cnt + CW'(1);
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (bus.err_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_gray_bad) begin
        r_gerr <= 1'b1;
      end else if (bus.err_clr) begin
        r_gerr <= 1'b0;
      end
    end
  end

  assign bus.g_rptr_sync = w_g;
  assign bus.b_rptr_sync = r_b_rptr;
  assign bus.w_level     = r_level;
  assign bus.almost_full = r_af;
  assign bus.overflow    = r_ovf;
  assign bus.gray_err    = r_gerr;
endmodule

// File: tb/tb_rptr_sync_decoder.sv
// Directed bench for rptr_sync_decoder at defaults (PTR_WIDTH=3, SYNC_STAGES=2, AF_THRESH=6).
module tb_rptr_sync_decoder;
  logic w_clk;
  logic w_rst;
  int   n_checks;
  int   n_fails;

  rptr_sync_decoder_if #(.PTR_WIDTH(3)) bus ();

  rptr_sync_decoder #(
    .PTR_WIDTH  (3),
    .SYNC_STAGES(2),
    .AF_THRESH  (6)
  ) dut (
    .w_clk(w_clk),
    .w_rst(w_rst),
    .bus  (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic reset_to(input logic [3:0] g, input logic [3:0] wp);
    w_rst       = 1'b1;
    bus.g_rptr  = g;
    bus.b_wptr  = wp;
    bus.w_en    = 1'b0;
    bus.full    = 1'b0;
    bus.err_clr = 1'b0;
    tick();
    tick();
    w_rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    // Reset with a nonzero pointer waiting at the input
    w_rst       = 1'b1;
    bus.g_rptr  = 4'b0110;
    bus.b_wptr  = 4'd4;
    bus.w_en    = 1'b0;
    bus.full    = 1'b0;
    bus.err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", {bus.g_rptr_sync, bus.b_rptr_sync, bus.w_level,
                          bus.almost_full, bus.overflow, bus.gray_err}, 32'h0);
    end
    w_rst = 1'b0;
    tick();
    chk("rel1_gsync", 32'(bus.g_rptr_sync), 32'h0);
    tick();
    chk("rel2_gsync", 32'(bus.g_rptr_sync), 32'h6);
    chk("rel2_bsync", 32'(bus.b_rptr_sync), 32'h0);
    tick();
    chk("rel3_bsync", 32'(bus.b_rptr_sync), 32'h4);
    tick();
    chk("rel4_level", 32'(bus.w_level), 32'h0);
    chk("rel4_gerr", 32'(bus.gray_err), 32'h0);

    // Level and almost-full threshold
    reset_to(4'b0001, 4'd7);
    chk("lvl_bsync", 32'(bus.b_rptr_sync), 32'h1);
    chk("lvl6_level", 32'(bus.w_level), 32'd6);
    chk("lvl6_af", 32'(bus.almost_full), 32'h1);
    bus.b_wptr = 4'd6;
    tick();
    chk("lvl5_level", 32'(bus.w_level), 32'd5);
    chk("lvl5_af", 32'(bus.almost_full), 32'h0);
    chk("lvl_gerr", 32'(bus.gray_err), 32'h0);

    // Pointer wrap-around
    reset_to(4'b1001, 4'b0001);
    chk("wrap_bsync", 32'(bus.b_rptr_sync), 32'd14);
    chk("wrap_level", 32'(bus.w_level), 32'd3);
    chk("wrap_gerr", 32'(bus.gray_err), 32'h0);

    // Completely full, overflow and clear
    reset_to(4'b0000, 4'b1000);
    chk("full_level", 32'(bus.w_level), 32'd8);
    chk("full_af", 32'(bus.almost_full), 32'h1);
    chk("full_gerr", 32'(bus.gray_err), 32'h0);
    bus.w_en = 1'b1;
    bus.full = 1'b1;
    tick();
    chk("ovf_set", 32'(bus.overflow), 32'h1);
    bus.w_en = 1'b0;
    tick();
    chk("ovf_hold", 32'(bus.overflow), 32'h1);
    bus.err_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(bus.overflow), 32'h0);

    // Clear collides with a new overflow: set wins
    bus.err_clr = 1'b0;
    bus.w_en    = 1'b1;
    tick();
    chk("coll_set", 32'(bus.overflow), 32'h1);
    bus.err_clr = 1'b1;
    tick();
    chk("coll_hold", 32'(bus.overflow), 32'h1);
    bus.w_en = 1'b0;
    tick();
    chk("coll_clr", 32'(bus.overflow), 32'h0);
    bus.err_clr = 1'b0;
    bus.full    = 1'b0;

    // Two-bit Gray step 0000 -> 0011
    bus.g_rptr = 4'b0011;
    tick();
    chk("gerr_edge1", 32'(bus.gray_err), 32'h0);
    tick();
    chk("gerr_edge2", 32'(bus.gray_err), 32'h1);
    tick();
    tick();
    chk("gerr_sticky", 32'(bus.gray_err), 32'h1);
    chk("gerr_bsync", 32'(bus.b_rptr_sync), 32'd2);
    chk("gerr_level", 32'(bus.w_level), 32'd6);
    bus.err_clr = 1'b1;
    tick();
    chk("gerr_clr", 32'(bus.gray_err), 32'h0);
    bus.err_clr = 1'b0;

    // Level beyond depth (11 - 2 = 9) is an integrity violation
    bus.b_wptr = 4'd11;
    tick();
    chk("lvl9_level", 32'(bus.w_level), 32'd9);
    chk("lvl9_gerr", 32'(bus.gray_err), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
